// File: rtl/bip_pkg.sv
// Shared BIP definitions: ACC source encodings, ALU op, default widths,
// control-unit opcodes and the clogb2 width helper.
package bip_pkg;

  localparam int unsigned DEF_NB_BITS        = 16;
  localparam int unsigned DEF_NB_SIGX        = 11;
  localparam int unsigned DEF_DATA_MEM_DEPTH = 1024;

  // ACC source select
  typedef enum logic [1:0] {
    SEL_A_MEM = 2'b00,
    SEL_A_IMM = 2'b01,
    SEL_A_ALU = 2'b10,
    SEL_A_ACC = 2'b11
  } sel_a_e;

  // ALU operation select
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // Instruction opcodes decoded by the control unit
  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  // Bits needed to represent value (minimum 1)
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned n;
    v = value;
    n = 0;
    while (v > 0) begin
      n = n + 1;
      v = v >> 1;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/bip_data_ram.sv
// BIP data RAM: one synchronous write port, two asynchronous read ports
// (execute and debug). Contents are not reset.
module bip_data_ram
  import bip_pkg::*;
#(
  parameter int unsigned NB_BITS        = DEF_NB_BITS,
  parameter int unsigned DATA_MEM_DEPTH = DEF_DATA_MEM_DEPTH,
  parameter int unsigned NB_ADDR        = clogb2(DATA_MEM_DEPTH - 1)
) (
  input  logic               i_clk,
  input  logic               i_wr,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_BITS-1:0] i_wr_data,
  output logic [NB_BITS-1:0] o_rd_data,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_BITS-1:0] o_dbg_data
);

  logic [NB_BITS-1:0] r_mem [DATA_MEM_DEPTH];

  // Write port; same-cycle reads see the old word
  always_ff @(posedge i_clk) begin
    if (i_wr) r_mem[i_addr] <= i_wr_data;
  end

  assign o_rd_data  = r_mem[i_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/bip_datapath.sv
// BIP datapath: ACC, add/sub ALU, operand sign extension and data RAM.
// Optional sticky signed-overflow flag enabled by macro BIP_OVF_FLAG_EN;
// without it o_ovf is tied low.
module bip_datapath
  import bip_pkg::*;
#(
  parameter int unsigned NB_BITS        = DEF_NB_BITS,
  parameter int unsigned NB_SIGX        = DEF_NB_SIGX,
  parameter int unsigned DATA_MEM_DEPTH = DEF_DATA_MEM_DEPTH,
  localparam int unsigned NB_ADDR       = clogb2(DATA_MEM_DEPTH - 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_SIGX-1:0] i_data_ins,
  input  logic [1:0]         i_sel_a,
  input  logic               i_sel_b,
  input  logic               i_wr_acc,
  input  logic               i_op_code,
  input  logic               i_wr,
  input  logic               i_rd,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_BITS-1:0] o_dbg_data,
  output logic [NB_BITS-1:0] o_acc,
  output logic               o_ovf
);

  logic [NB_BITS-1:0] r_acc;
  logic [NB_BITS-1:0] w_imm;
  logic [NB_ADDR-1:0] w_addr;
  logic [NB_BITS-1:0] w_ram_rd;
  logic [NB_BITS-1:0] w_mem;
  logic [NB_BITS-1:0] w_b;
  logic [NB_BITS-1:0] w_alu;
  logic [NB_BITS-1:0] w_acc_next;

  assign w_imm  = {{(NB_BITS-NB_SIGX){i_data_ins[NB_SIGX-1]}}, i_data_ins};
  assign w_addr = i_data_ins[NB_ADDR-1:0];
  assign w_mem  = i_rd ? w_ram_rd : '0;
  assign w_b    = i_sel_b ? w_imm : w_mem;
  assign w_alu  = (i_op_code == OP_ADD) ? NB_BITS'(r_acc + w_b) : NB_BITS'(r_acc - w_b);

  // RAM writes are blocked while reset is asserted
  bip_data_ram #(
    .NB_BITS        (NB_BITS),
    .DATA_MEM_DEPTH (DATA_MEM_DEPTH),
    .NB_ADDR        (NB_ADDR)
  ) u_ram (
    .i_clk      (i_clk),
    .i_wr       (i_wr & ~i_rst),
    .i_addr     (w_addr),
    .i_wr_data  (r_acc),
    .o_rd_data  (w_ram_rd),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  // ACC source mux
  always_comb begin
    w_acc_next = r_acc;
    case (sel_a_e'(i_sel_a))
      SEL_A_MEM: w_acc_next = w_mem;
      SEL_A_IMM: w_acc_next = w_imm;
      SEL_A_ALU: w_acc_next = w_alu;
      default:   w_acc_next = r_acc;
    endcase
  end

  // Accumulator register
  always_ff @(posedge i_clk) begin
    if (i_rst)         r_acc <= '0;
    else if (i_wr_acc) r_acc <= w_acc_next;
  end

  assign o_acc = r_acc;

`ifdef BIP_OVF_FLAG_EN
  logic r_ovf;
  logic w_acc_s;
  logic w_b_s;
  logic w_alu_s;
  logic w_ovf;

  assign w_acc_s = r_acc[NB_BITS-1];
  assign w_b_s   = w_b[NB_BITS-1];
  assign w_alu_s = w_alu[NB_BITS-1];
  assign w_ovf   = (i_op_code == OP_ADD) ? ((w_acc_s == w_b_s) && (w_alu_s != w_acc_s))
                                         : ((w_acc_s != w_b_s) && (w_alu_s != w_acc_s));

  // Sticky overflow, only for ALU results actually loaded into ACC
  always_ff @(posedge i_clk) begin
    if (i_rst) r_ovf <= 1'b0;
    else if (i_wr_acc && (sel_a_e'(i_sel_a) == SEL_A_ALU) && w_ovf) r_ovf <= 1'b1;
  end

  assign o_ovf = r_ovf;
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bip_datapath.sv
// Directed self-checking bench for bip_datapath.
module tb_bip_datapath;

  logic        clk;
  logic        rst;
  logic [10:0] data_ins;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic        wr_acc;
  logic        op_code;
  logic        wr;
  logic        rd;
  logic [9:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] acc;
  logic        ovf;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef BIP_OVF_FLAG_EN
  localparam logic [15:0] EXP_OVF = 16'd1;
`else
  localparam logic [15:0] EXP_OVF = 16'd0;
`endif

  bip_datapath dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data_ins (data_ins),
    .i_sel_a    (sel_a),
    .i_sel_b    (sel_b),
    .i_wr_acc   (wr_acc),
    .i_op_code  (op_code),
    .i_wr       (wr),
    .i_rd       (rd),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data),
    .o_acc      (acc),
    .o_ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  task automatic halt_inputs();
    data_ins = '0; sel_a = 2'b11; sel_b = 1'b0; wr_acc = 1'b0;
    op_code = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  // Apply one control word for one edge, then return to halt
  task automatic instr(input logic [10:0] d, input logic [1:0] sa, input logic sb,
                       input logic wa, input logic op, input logic w, input logic r);
    data_ins = d; sel_a = sa; sel_b = sb; wr_acc = wa; op_code = op; wr = w; rd = r;
    @(posedge clk);
    #1;
    halt_inputs();
  endtask

  task automatic ldi(input logic [10:0] d);  instr(d, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic sto(input logic [10:0] a);  instr(a, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic ld(input logic [10:0] a);   instr(a, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); endtask
  task automatic addv(input logic [10:0] a); instr(a, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); endtask
  task automatic subv(input logic [10:0] a); instr(a, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); endtask
  task automatic addi(input logic [10:0] d); instr(d, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); endtask

  initial begin
    halt_inputs();
    dbg_addr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_acc", acc, 16'h0000);
    check("reset_ovf", 16'(ovf), 16'h0000);

    // 1: LDI / STO
    ldi(11'h005);
    check("ldi5_acc", acc, 16'h0005);
    sto(11'd3);
    dbg_addr = 10'd3; #1;
    check("sto3_ram", dbg_data, 16'h0005);
    check("sto3_acc", acc, 16'h0005);
    instr(11'd0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_sel11", acc, 16'h0005);

    // 2: ADDI -1, SUB var
    addi(11'h7FF);
    check("addi_m1", acc, 16'h0004);
    subv(11'd3);
    check("sub_var3", acc, 16'hFFFF);
    check("sub_ovf", 16'(ovf), 16'h0000);

    // 3: sign extension, LD var
    ldi(11'h400);
    check("ldi_sext", acc, 16'hFC00);
    ld(11'd3);
    check("ld_var3", acc, 16'h0005);

    // mem forced to 0 when rd is low
    ldi(11'h007);
    instr(11'd3, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("add_rd0", acc, 16'h0007);

    // 4: doubling to the edge of positive range, then overflow
    ldi(11'h3FF);
    for (int i = 0; i < 5; i++) begin
      sto(11'd0);
      addv(11'd0);
    end
    check("dbl_acc", acc, 16'h7FE0);
    check("dbl_ovf", 16'(ovf), 16'h0000);
    addi(11'h020);
    check("ovf_acc", acc, 16'h8000);
    check("ovf_set", 16'(ovf), EXP_OVF);
    ldi(11'h000);
    check("ovf_sticky_acc", acc, 16'h0000);
    check("ovf_sticky", 16'(ovf), EXP_OVF);

    // 5: store and load the same address in one cycle
    ldi(11'h123);
    sto(11'd2);
    ldi(11'h009);
    dbg_addr = 10'd2;
    data_ins = 11'd2; sel_a = 2'b00; wr = 1'b1; wr_acc = 1'b1; rd = 1'b1;
    #1;
    check("rdw_old_dbg", dbg_data, 16'h0123);
    @(posedge clk);
    #1;
    halt_inputs();
    check("rdw_acc", acc, 16'h0123);
    check("rdw_ram", dbg_data, 16'h0009);

    // 6: reset wins over write strobes
    dbg_addr = 10'd3;
    rst = 1'b1;
    data_ins = 11'd3; sel_a = 2'b01; wr = 1'b1; wr_acc = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    halt_inputs();
    check("rst_ram3", dbg_data, 16'h0005);
    check("rst_acc", acc, 16'h0000);
    check("rst_ovf", 16'(ovf), 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("halt_acc", acc, 16'h0000);
      check("halt_ram3", dbg_data, 16'h0005);
    end

    // Address aliasing: upper operand bit ignored
    ldi(11'h011);
    sto(11'h403);
    check("alias_ram3", dbg_data, 16'h0011);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
